// File: rtl/fetch_unit_pkg.sv
// Purpose: shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

   localparam int PC_W_DEF  = 10;
   localparam int IW_DEF    = 16;
   localparam int RESET_VEC = 0;

   // Opcode field position inside the instruction word
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 10;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Purpose: program-memory read port between fetch unit (master) and memory (slave).
// Latency: request held until ack; ack may arrive in the same cycle as the request.
// Backpressure: memory stalls the fetch by withholding mem_ack.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF,
   parameter int IW   = IW_DEF
);

   logic            mem_req;
   logic [PC_W-1:0] mem_addr;
   logic            mem_ack;
   logic [IW-1:0]   mem_data;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_data
   );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Purpose: next fetch address select: absolute jump, relative jump or sequential.
// Latency: combinational.
// Backpressure: none.
module pc_next
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            s_abs,
   input  logic            s_inc,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] d,
   output logic [PC_W-1:0] nxt
);

   // Absolute jump wins over relative; wrap-around is the natural PC_W-bit overflow,
   // so a negative two's-complement D steps backwards.
   always_comb begin
      nxt = pc + PC_W'(1);
      if (!s_abs) begin
         nxt = d;
      end else if (!s_inc) begin
         nxt = pc + d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: fetch/execute sequencer; fetches one instruction word and strobes exec for it.
// Latency: 2 cycles per instruction with zero-wait memory, plus one per memory wait state.
// Backpressure: FETCH holds mem_req/mem_addr stable until mem_ack; acks outside FETCH ignored.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF,
   parameter int IW   = IW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_abs,
   input  logic             s_inc,
   fetch_unit_if.master     mem,
   output logic [IW-1:0]    instr,
   output logic [OPC_W-1:0] opcode,
   output logic [PC_W-1:0]  jdest,
   output logic             exec,
   output logic [PC_W-1:0]  pc
);

   state_e          state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [IW-1:0]   instr_q, instr_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            exec_q, exec_d;
   logic [PC_W-1:0] pc_nxt;

   pc_next #(.PC_W(PC_W)) u_pc_next (
      .s_abs (s_abs),
      .s_inc (s_inc),
      .pc    (pc_q),
      .d     (instr_q[PC_W-1:0]),
      .nxt   (pc_nxt)
   );

   // Sequencer: all outputs are registered, so each transition also sets the
   // next cycle's mem_req/exec values.
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      fetch_addr_d = fetch_addr_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      exec_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d   = ST_FETCH;
            mem_req_d = 1'b1;
         end
         ST_FETCH: begin
            if (mem.mem_ack) begin
               instr_d   = mem.mem_data;
               pc_d      = fetch_addr_q;
               mem_req_d = 1'b0;
               exec_d    = 1'b1;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Control inputs are sampled here, while exec is high
            fetch_addr_d = pc_nxt;
            mem_req_d    = 1'b1;
            state_d      = ST_FETCH;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any outstanding request immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         mem_req_q    <= 1'b0;
         fetch_addr_q <= PC_W'(RESET_VEC);
         instr_q      <= '0;
         pc_q         <= PC_W'(RESET_VEC);
         exec_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         fetch_addr_q <= fetch_addr_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         exec_q       <= exec_d;
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = fetch_addr_q;
   assign instr        = instr_q;
   assign opcode       = instr_q[OPC_MSB:OPC_LSB];
   assign jdest        = instr_q[PC_W-1:0];
   assign exec         = exec_q;
   assign pc           = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory-side driver plays directed instruction vectors,
// pushing expected executions and fetch addresses into queues; a monitor pops them.
module tb_fetch_unit;

   typedef struct {
      logic [9:0]  addr;   // address this word is fetched from
      logic [15:0] data;   // word returned by memory
      int          waits;  // wait states before ack
      logic        s_abs;
      logic        s_inc;
      logic [9:0]  nxt;    // hand-computed next fetch address
      bit          spur;   // drive a spurious ack of 0xFFFF during EXEC
   } vec_t;

   typedef struct {
      logic [9:0]  pc;
      logic [15:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        s_abs = 1'b1;
   logic        s_inc = 1'b1;
   logic [15:0] instr;
   logic [5:0]  opcode;
   logic [9:0]  jdest;
   logic        exec;
   logic [9:0]  pc;

   int checks = 0;
   int errors = 0;
   int exec_cnt = 0;
   int n_exp = 0;
   int cyc = 0;
   int last_exec_cyc = 0;
   int rel_cyc = 0;

   exp_t       exp_q[$];
   logic [9:0] addr_q[$];
   vec_t       vq[$];

   fetch_unit_if #(.PC_W(10), .IW(16)) mif ();

   fetch_unit #(.PC_W(10), .IW(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .s_abs  (s_abs),
      .s_inc  (s_inc),
      .mem    (mif),
      .instr  (instr),
      .opcode (opcode),
      .jdest  (jdest),
      .exec   (exec),
      .pc     (pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no matching event, expected one (t=%0t)", name, $time);
   endtask

   // Plays one vector from the memory side; entered and left at a negedge
   task automatic run_vec(input vec_t v);
      int t;
      t = 0;
      while (mif.mem_req !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (mif.mem_req !== 1'b1) begin
         fail("req_timeout");
         return;
      end
      for (int w = 0; w < v.waits; w++) begin
         mif.mem_ack  = 1'b0;
         mif.mem_data = 16'hDEAD;
         @(negedge clk);
         chk("req_held", 32'(mif.mem_req), 32'd1);
      end
      mif.mem_ack  = 1'b1;
      mif.mem_data = v.data;
      exp_q.push_back('{pc: v.addr, instr: v.data});
      n_exp++;
      @(negedge clk);
      // EXEC cycle: control inputs select the next address
      s_abs = v.s_abs;
      s_inc = v.s_inc;
      addr_q.push_back(v.nxt);
      mif.mem_ack  = v.spur;
      mif.mem_data = v.spur ? 16'hFFFF : 16'hDEAD;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      s_abs = 1'b1;
      s_inc = 1'b1;
      if (v.spur) begin
         chk("spur_exec_instr", 32'(instr), 32'(v.data));
         chk("spur_exec_pc", 32'(pc), 32'(v.addr));
      end
   endtask

   // Monitor: checks each new request address, its stability, and every exec pulse
   logic       prev_req = 1'b0;
   logic       prev_exec = 1'b0;
   logic [9:0] cur_addr = '0;
   exp_t       mon_e;
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mif.mem_req === 1'b1) begin
            if (prev_req !== 1'b1) begin
               if (addr_q.size() == 0) fail("unexpected_req");
               else begin
                  cur_addr = addr_q.pop_front();
                  chk("fetch_addr", 32'(mif.mem_addr), 32'(cur_addr));
               end
            end else begin
               chk("addr_stable", 32'(mif.mem_addr), 32'(cur_addr));
            end
         end
         if (exec === 1'b1) begin
            exec_cnt++;
            last_exec_cyc = cyc;
            chk("exec_one_cycle", 32'(prev_exec), 32'd0);
            chk("exec_no_req", 32'(mif.mem_req), 32'd0);
            if (exp_q.size() == 0) fail("unexpected_exec");
            else begin
               mon_e = exp_q.pop_front();
               chk("exec_pc", 32'(pc), 32'(mon_e.pc));
               chk("exec_instr", 32'(instr), 32'(mon_e.instr));
               chk("exec_opcode", 32'(opcode), 32'(mon_e.instr[15:10]));
               chk("exec_jdest", 32'(jdest), 32'(mon_e.instr[9:0]));
            end
         end
         prev_req  = mif.mem_req;
         prev_exec = exec;
      end
   end

   initial begin : driver
      mif.mem_ack  = 1'b0;
      mif.mem_data = 16'h0000;
      //                addr    data      w  abs   inc   nxt     spur
      vq.push_back('{10'h000, 16'h2000, 0, 1'b1, 1'b1, 10'h001, 1'b0});
      vq.push_back('{10'h001, 16'h1C55, 3, 1'b1, 1'b1, 10'h002, 1'b0});
      vq.push_back('{10'h002, 16'h0010, 0, 1'b0, 1'b1, 10'h010, 1'b0});
      vq.push_back('{10'h010, 16'h4523, 0, 1'b0, 1'b1, 10'h123, 1'b1});
      vq.push_back('{10'h123, 16'h0010, 1, 1'b0, 1'b1, 10'h010, 1'b0});
      vq.push_back('{10'h010, 16'hFD23, 0, 1'b0, 1'b0, 10'h123, 1'b0});
      vq.push_back('{10'h123, 16'h0005, 0, 1'b0, 1'b1, 10'h005, 1'b0});
      vq.push_back('{10'h005, 16'h07FE, 1, 1'b1, 1'b0, 10'h003, 1'b0});
      vq.push_back('{10'h003, 16'h03FF, 2, 1'b0, 1'b1, 10'h3FF, 1'b0});
      vq.push_back('{10'h3FF, 16'h0000, 0, 1'b1, 1'b1, 10'h000, 1'b1});
      vq.push_back('{10'h000, 16'hABCD, 0, 1'b1, 1'b0, 10'h3CD, 1'b0});
      vq.push_back('{10'h3CD, 16'h0C04, 0, 1'b1, 1'b0, 10'h3D1, 1'b0});

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
      chk("rst_exec", 32'(exec), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);

      addr_q.push_back(10'h000);
      reset   = 1'b1;
      rel_cyc = cyc;
      run_vec(vq[0]);
      chk("first_exec_cycle", 32'(last_exec_cyc - rel_cyc), 32'd2);
      for (int i = 1; i < vq.size(); i++) run_vec(vq[i]);

      // Reset while a fetch is outstanding and acked in the same cycle
      begin
         int t;
         t = 0;
         while (mif.mem_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
      chk("abort_req_up", 32'(mif.mem_req), 32'd1);
      mif.mem_ack  = 1'b1;
      mif.mem_data = 16'h1234;
      #2 reset = 1'b0;
      #1;
      chk("async_req_drop", 32'(mif.mem_req), 32'd0);
      chk("async_instr", 32'(instr), 32'd0);
      chk("async_pc", 32'(pc), 32'd0);
      chk("async_exec", 32'(exec), 32'd0);
      @(negedge clk);
      chk("abort_instr", 32'(instr), 32'd0);
      chk("abort_exec", 32'(exec), 32'd0);
      chk("abort_addr", 32'(mif.mem_addr), 32'd0);

      // Release with a spurious ack during IDLE
      addr_q.push_back(10'h000);
      mif.mem_ack  = 1'b1;
      mif.mem_data = 16'hFFFF;
      reset   = 1'b1;
      rel_cyc = cyc;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      chk("idle_spur_instr", 32'(instr), 32'd0);
      chk("idle_spur_pc", 32'(pc), 32'd0);
      run_vec('{10'h000, 16'h2000, 0, 1'b1, 1'b1, 10'h001, 1'b0});
      chk("restart_exec_cycle", 32'(last_exec_cyc - rel_cyc), 32'd2);

      repeat (3) @(negedge clk);
      chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("exec_count", 32'(exec_cnt), 32'(n_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
